// File: rtl/vega_axil_master_if.sv
// Command/response stream plus AXI4-Lite initiator bus for vega_axil_master.
// Modport master is the block's view; slave is the sequencer/interconnect view.
interface vega_axil_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_wstrb;
    logic                  rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  busy;
    logic [ADDR_W-1:0]     m_axi_awaddr;
    logic                  m_axi_awvalid, m_axi_awready;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [DATA_W/8-1:0]   m_axi_wstrb;
    logic                  m_axi_wvalid, m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid, m_axi_bready;
    logic [ADDR_W-1:0]     m_axi_araddr;
    logic                  m_axi_arvalid, m_axi_arready;
    logic [DATA_W-1:0]     m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid, m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout, busy,
               m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout, busy,
               m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
    );
endinterface

// File: rtl/vega_axil_master.sv
// AXI4-Lite initiator: one command in, one single-beat transaction, one response out.
// Optional watchdog abort enabled by defining VEGA_AXIL_MASTER_TIMEOUT_EN.
module vega_axil_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                 s_axi_aclk,
    input logic                 s_axi_aresetn,
    vega_axil_master_if.master  bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          resp_q, resp_d;

`ifdef VEGA_AXIL_MASTER_TIMEOUT_EN
    localparam int            CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
`ifdef VEGA_AXIL_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                // cmd_ready_q is low for the first cycle out of reset
                if (cmd_ready_q && bus.cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    rsp_write_d = bus.cmd_write;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    wstrb_d     = bus.cmd_wstrb;
                    rdata_d     = '0;
                    resp_d      = 2'b00;
`ifdef VEGA_AXIL_MASTER_TIMEOUT_EN
                    cnt_d       = CNT_W'(1);
                    tmo_d       = 1'b0;
`endif
                    if (bus.cmd_write) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                if (awvalid_q && bus.m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end
            WR_B: begin
                bready_d = 1'b1;
                if (bready_q && bus.m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    resp_d      = bus.m_axi_bresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_AR: begin
                arvalid_d = 1'b1;
                if (arvalid_q && bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                rready_d = 1'b1;
                if (rready_q && bus.m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rdata_d     = bus.m_axi_rdata;
                    resp_d      = bus.m_axi_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                rsp_valid_d = 1'b1;
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef VEGA_AXIL_MASTER_TIMEOUT_EN
        // A handshake completing on the limit edge still wins over the abort.
        if (state_q != IDLE && state_q != RSP && state_d != RSP) begin
            if (cnt_q == TMO_LIMIT) begin
                state_d     = RSP;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rdata_d     = '0;
                resp_d      = 2'b10;
                tmo_d       = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= 2'b00;
`ifdef VEGA_AXIL_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
`ifdef VEGA_AXIL_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

`ifdef VEGA_AXIL_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo      = (TIMEOUT_CYCLES < 2);
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.busy          = busy_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_resp      = resp_q;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
endmodule
